aes_dec: RTL and testbench
==========================

// Module: aes_dec
// PURPOSE
//  Iterative AES-128 decryption core; inverse of aes_enc, one round per clock.
//  Takes a 128-bit ciphertext and the cipher key, returns the plaintext.
//  Key schedule is run forward internally to reach the last round key, then walked back.
//  Byte order matches aes_enc (FIPS-197 byte 0 at [127:120], column c at [127-32c:96-32c]).
//  So aes_dec(aes_enc(x,k),k)==x.
// PARAMETERS
//  KEY_IS_LAST  0  1: key_i is round key 10 (pre-expanded), KEXP phase skipped
// PORTS
//  clk        in   1    clock, rising edge
//  nreset     in   1    asynchronous active-low reset
//  data_v_i   in   1    ciphertext/key valid; accepted only when ready_o=1
//  data_i     in   128  ciphertext
//  key_i      in   128  cipher key (round key 0), or round key 10 if KEY_IS_LAST=1
//  ready_o    out  1    core can accept a new block this cycle
//  res_v_o    out  1    one-cycle pulse: res_o holds valid plaintext
//  res_o      out  128  plaintext; held until the next accepted block completes
// BEHAVIOUR
//  Reset (async assert, sync release): fsm=IDLE, ready_o=1, res_v_o=0, res_o=0, counter=0.
//  Reset mid-operation aborts the block: no res_v_o; state/key regs may keep stale data.
//  States: IDLE, KEXP, ADDK, ROUND, DONE. Round counter rnd_q, 4 bits.
//  IDLE/DONE: ready_o=1. Accept (data_v_i&ready_o) loads state_q<=data_i, key_q<=key_i.
//   Next state is KEXP with rnd_q=1 (KEY_IS_LAST=0), or ADDK (KEY_IS_LAST=1).
//   No accept: DONE->IDLE, IDLE stays.
//  KEXP: key_q<=fwd_expand(key_q,Rcon[rnd_q]); rnd_q++. After rnd_q==10 -> ADDK.
//   Result: key_q=k10.
//  ADDK: state_q<=state_q^k10; key_q<=inv_expand(k10,Rcon[10])=k9; rnd_q<=9; ->ROUND.
//  ROUND, rnd_q=r in 9..1: state_q<=InvMixColumns(InvSubBytes(InvShiftRows(state_q))^k_r).
//   Same cycle: key_q<=inv_expand(k_r,Rcon[r]); rnd_q--.
//  ROUND, rnd_q=0: state_q<=InvSubBytes(InvShiftRows(state_q))^k0, no InvMixColumns. ->DONE.
//  DONE: res_v_o=1 for exactly that cycle; res_o=state_q (res_o tracks state_q only in DONE).
//   res_o is held in its own register.
//  Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36.
//   Forward step: w0'=w0^SubWord(RotWord(w3))^{Rcon,000000}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
//   Inverse step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{Rcon,000000}.
//  Latency, accept edge to res_v_o high: 22 cycles (KEY_IS_LAST=0), 12 cycles (KEY_IS_LAST=1).
//  ready_o=0 in KEXP/ADDK/ROUND; data_v_i there is ignored, no queuing.
//  Accept in DONE is legal (back-to-back): res_v_o still pulses for the finished block.
//   That same edge loads the new block.
//  InvSubBytes is a new inverse s-box (aes_inv_sbox, 16 instances).
//   Forward SubWord in the key path reuses aes_sbox (4 instances).
//  All GF(2^8) ops use polynomial 0x11b. InvMixColumns matrix rows: 0e 0b 0d 09, rotated.
// TESTING
//  1. FIPS C.1 vector, KEY_IS_LAST=0.
//     key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//     Required: res_o=00112233445566778899aabbccddeeff, res_v_o 22 cycles after accept.
//  2. FIPS B vector, KEY_IS_LAST=1.
//     key_i d014f9a8c9ee2589e13f0cc8b6630ca6, ct 3925841d02dc09fbdc118597196a0b32.
//     Required: res_o=3243f6a8885a308d313198a2e0370734 after 12 cycles.
//  3. Busy input: hold data_v_i=1 with changing data throughout a block.
//     Required: only the first accept takes effect.
//     ready_o=0 from accept+1 until DONE; exactly one res_v_o pulse.
//  4. Back-to-back: accept vector 2 in the DONE cycle of vector 1.
//     Required: both results correct, res_o holds result 1 until block 2's DONE.
//  5. Reset: drop nreset asynchronously at ROUND rnd_q=5.
//     Required: immediate ready_o=1, res_v_o=0, res_o=0. Next block decodes correctly.
//  6. Loopback with aes_enc: 1000 random (key, pt) pairs.
//     Required: aes_dec(aes_enc(pt))==pt, and a zero key/zero data case passes.

Source files
------------

// File: rtl/aes_dec.sv
// Iterative AES-128 decryption core, one inverse round per clock.
// The key schedule runs forward to round key 10, then steps back one key per round.

package aes_dec_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

endpackage

module aes_gf_inv (
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);
    import aes_dec_pkg::*;

    logic [7:0] sq;
    logic [7:0] acc;

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the s-box needs
    always_comb begin
        sq  = a_i;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        inv_o = acc;
    end
endmodule

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    import aes_dec_pkg::*;

    logic [7:0] inv;

    aes_gf_inv u_inv (.a_i(in_i), .inv_o(inv));

    assign out_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    import aes_dec_pkg::*;

    logic [7:0] pre;

    // undo the affine map first, then invert
    assign pre = rotl8(in_i, 1) ^ rotl8(in_i, 3) ^ rotl8(in_i, 6) ^ 8'h05;

    aes_gf_inv u_inv (.a_i(pre), .inv_o(out_o));
endmodule

module aes_dec #(
    parameter bit KEY_IS_LAST = 1'b0
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         data_v_i,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic         ready_o,
    output logic         res_v_o,
    output logic [127:0] res_o
);
    import aes_dec_pkg::*;

    typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] res_q, res_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         res_v_q, res_v_d;

    logic [7:0]   rcon;
    logic [31:0]  sw_in, sw_out, w0_new;
    logic [31:0]  fw1, fw2, fw3, iw1, iw2, iw3;
    logic [127:0] key_fwd, key_inv;
    logic [127:0] shifted, subbed, added, mixed;

    always_comb begin
        case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // The inverse step feeds SubWord with the recovered w3 (w3^w2), the forward step with the old w3
    assign iw3   = key_q[31:0]  ^ key_q[63:32];
    assign iw2   = key_q[63:32] ^ key_q[95:64];
    assign iw1   = key_q[95:64] ^ key_q[127:96];
    assign sw_in = (fsm_q == KEXP) ? key_q[31:0] : iw3;

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox u_sbox (.in_i(sw_in[8*i +: 8]), .out_o(sw_out[8*i +: 8]));
    end

    assign w0_new  = key_q[127:96] ^ {sw_out[23:0], sw_out[31:24]} ^ {rcon, 24'h000000};
    assign fw1     = key_q[95:64] ^ w0_new;
    assign fw2     = key_q[63:32] ^ fw1;
    assign fw3     = key_q[31:0]  ^ fw2;
    assign key_fwd = {w0_new, fw1, fw2, fw3};
    assign key_inv = {w0_new, iw1, iw2, iw3};

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign shifted[127-8*(4*c+r) -: 8] = state_q[127-8*SRC -: 8];
            aes_inv_sbox u_isbox (
                .in_i (shifted[127-8*(4*c+r) -: 8]),
                .out_o(subbed[127-8*(4*c+r) -: 8])
            );
        end

        logic [7:0] a0, a1, a2, a3;
        assign a0 = added[127-32*c -: 8];
        assign a1 = added[119-32*c -: 8];
        assign a2 = added[111-32*c -: 8];
        assign a3 = added[103-32*c -: 8];

        assign mixed[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign mixed[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign mixed[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign mixed[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

    assign added = subbed ^ key_q;

    // rnd_q parks at 10 on entry to ADDK so rcon selects Rcon[10] there
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        res_d   = res_q;
        res_v_d = 1'b0;
        ready_o = 1'b0;
        case (fsm_q)
            IDLE, DONE: begin
                ready_o = 1'b1;
                if (fsm_q == DONE) begin
                    res_d   = state_q;
                    res_v_d = 1'b1;
                    fsm_d   = IDLE;
                end
                if (data_v_i) begin
                    state_d = data_i;
                    key_d   = key_i;
                    if (KEY_IS_LAST) begin
                        fsm_d = ADDK;
                        rnd_d = 4'd10;
                    end else begin
                        fsm_d = KEXP;
                        rnd_d = 4'd1;
                    end
                end
            end
            KEXP: begin
                key_d = key_fwd;
                if (rnd_q == 4'd10) fsm_d = ADDK;
                else                rnd_d = rnd_q + 4'd1;
            end
            ADDK: begin
                state_d = state_q ^ key_q;
                key_d   = key_inv;
                rnd_d   = 4'd9;
                fsm_d   = ROUND;
            end
            ROUND: begin
                if (rnd_q == 4'd0) begin
                    state_d = added;
                    fsm_d   = DONE;
                end else begin
                    state_d = mixed;
                    key_d   = key_inv;
                    rnd_d   = rnd_q - 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
            res_q   <= '0;
            res_v_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            res_q   <= res_d;
            res_v_q <= res_v_d;
        end
    end

    assign res_o   = res_q;
    assign res_v_o = res_v_q;

endmodule

// File: tb/tb_aes_dec.sv
// Directed and loopback bench for aes_dec: one core with KEY_IS_LAST=0, one with KEY_IS_LAST=1.
// Expected plaintexts come from FIPS-197 vectors and a behavioural AES encryptor.
`timescale 1ns/1ps

module tb_aes_dec;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [127:0] d0 = '0, k0 = '0, d1 = '0, k1 = '0;
    logic         rdy0, rv0, rdy1, rv1;
    logic [127:0] res0, res1;

    int nCompared = 0;
    int nMismatched = 0;

    logic [7:0]   sbox [256];
    int           lat, pulses, t1, t2, badCount;
    logic         rdyA, rdyB, holdOk;
    logic [127:0] res, r1, r2, key, pt, ct;

    aes_dec #(.KEY_IS_LAST(1'b0)) u_dut0 (
        .clk(clk), .nreset(nreset), .data_v_i(v0), .data_i(d0), .key_i(k0),
        .ready_o(rdy0), .res_v_o(rv0), .res_o(res0)
    );

    aes_dec #(.KEY_IS_LAST(1'b1)) u_dut1 (
        .clk(clk), .nreset(nreset), .data_v_i(v1), .data_i(d1), .key_i(k1),
        .ready_o(rdy1), .res_v_o(rv1), .res_o(res1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Build the forward s-box by walking the multiplicative group generated by 3
    task automatic initSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] encRound(input logic [127:0] s, input logic [127:0] rk, input bit mix);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aesEnc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, kk;
        logic [7:0]   rc;
        s  = p ^ k;
        kk = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            kk = nextKey(kk, rc);
            s  = encRound(s, kk, r != 10);
            rc = xt(rc);
        end
        return s;
    endfunction

    function automatic logic [127:0] lastKey(input logic [127:0] k);
        logic [127:0] kk;
        logic [7:0]   rc;
        kk = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            kk = nextKey(kk, rc);
            rc = xt(rc);
        end
        return kk;
    endfunction

    // Offer one block, then wait (bounded) for the result pulse; lat stays -1 on timeout
    task automatic applyStimulus(input bit which, input logic [127:0] c, input logic [127:0] k,
                                 output int l, output logic [127:0] r);
        int w;
        w = 0;
        while (((which ? rdy1 : rdy0) !== 1'b1) && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (which) begin v1 = 1'b1; d1 = c; k1 = k; end
        else       begin v0 = 1'b1; d0 = c; k0 = k; end
        @(posedge clk); #1;
        v0 = 1'b0;
        v1 = 1'b0;
        l = -1;
        r = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if ((which ? rv1 : rv0) === 1'b1) begin
                l = n;
                r = which ? res1 : res0;
                break;
            end
        end
    endtask

    initial begin
        initSbox();

        #12;
        checkOutput("reset ready0", 128'(rdy0), 128'(1));
        checkOutput("reset resv0", 128'(rv0), 128'(0));
        checkOutput("reset res0", res0, '0);
        checkOutput("reset ready1", 128'(rdy1), 128'(1));
        checkOutput("reset resv1", 128'(rv1), 128'(0));
        checkOutput("reset res1", res1, '0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, CT_C1, KEY_C1, lat, res);
        checkOutput("C1 result", res, PT_C1);
        checkOutput("C1 latency", 128'(lat), 128'(22));

        applyStimulus(1'b1, CT_B, K10_B, lat, res);
        checkOutput("B last-key result", res, PT_B);
        checkOutput("B last-key latency", 128'(lat), 128'(12));

        applyStimulus(1'b0, CT_Z, '0, lat, res);
        checkOutput("zero key/data", res, '0);

        // Busy: data_v_i held high with changing data until the DONE cycle
        v1 = 1'b1; d1 = CT_B; k1 = K10_B;
        @(posedge clk); #1;
        badCount = 0; pulses = 0; t1 = -1; r1 = '0; rdyA = 1'b0;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            if (cyc <= 10 && rdy1 !== 1'b0) badCount++;
            if (cyc == 11) begin
                rdyA = rdy1;
                v1 = 1'b0;
            end else if (cyc < 11) begin
                d1 = {$urandom, $urandom, $urandom, $urandom};
                k1 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (rv1 === 1'b1) begin
                pulses++;
                t1 = cyc;
                r1 = res1;
            end
            @(posedge clk); #1;
        end
        checkOutput("busy ready low", 128'(badCount), 128'(0));
        checkOutput("busy ready at DONE", 128'(rdyA), 128'(1));
        checkOutput("busy pulse count", 128'(pulses), 128'(1));
        checkOutput("busy pulse cycle", 128'(t1), 128'(12));
        checkOutput("busy result", r1, PT_B);

        // Back-to-back: second block accepted in the DONE cycle of the first
        v0 = 1'b1; d0 = CT_C1; k0 = KEY_C1;
        @(posedge clk); #1;
        v0 = 1'b0;
        pulses = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0; holdOk = 1'b1; rdyA = 1'b0; rdyB = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(posedge clk); #1;
            if (rv0 === 1'b1) begin
                pulses++;
                if (pulses == 1) begin t1 = cyc; r1 = res0; end
                else             begin t2 = cyc; r2 = res0; end
            end
            if (cyc == 21) begin
                rdyA = rdy0;
                v0 = 1'b1; d0 = CT_B; k0 = KEY_B;
            end
            if (cyc == 22) v0 = 1'b0;
            if (cyc == 23) rdyB = rdy0;
            if (cyc > 22 && cyc < 44 && res0 !== PT_C1) holdOk = 1'b0;
        end
        checkOutput("b2b ready in DONE", 128'(rdyA), 128'(1));
        checkOutput("b2b first cycle", 128'(t1), 128'(22));
        checkOutput("b2b first result", r1, PT_C1);
        checkOutput("b2b second busy", 128'(rdyB), 128'(0));
        checkOutput("b2b result held", 128'(holdOk), 128'(1));
        checkOutput("b2b second cycle", 128'(t2), 128'(44));
        checkOutput("b2b second result", r2, PT_B);
        checkOutput("b2b pulse count", 128'(pulses), 128'(2));

        // Reset while the first core sits in ROUND with rnd_q=5
        v0 = 1'b1; d0 = CT_C1; k0 = KEY_C1;
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("abort ready", 128'(rdy0), 128'(1));
        checkOutput("abort resv", 128'(rv0), 128'(0));
        checkOutput("abort res", res0, '0);
        @(negedge clk);
        nreset = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(posedge clk); #1;
            if (rv0 === 1'b1) pulses++;
        end
        checkOutput("abort no pulse", 128'(pulses), 128'(0));
        applyStimulus(1'b0, CT_C1, KEY_C1, lat, res);
        checkOutput("post-reset result", res, PT_C1);
        checkOutput("post-reset latency", 128'(lat), 128'(22));

        // Loopback against the behavioural encryptor
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            if (n == 0) begin
                key = '0;
                pt  = '0;
            end
            ct = aesEnc(pt, key);
            applyStimulus(1'b0, ct, key, lat, res);
            checkOutput("loopback", res, pt);
        end
        for (int n = 0; n < 100; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ct  = aesEnc(pt, key);
            applyStimulus(1'b1, ct, lastKey(key), lat, res);
            checkOutput("loopback last-key", res, pt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
